// File: rtl/anticipator_req_stage.sv
// Request stage for the 4-port anticipator RAM: forms per-slot lookup indices,
// captures the returned hints and buffers them in a 2-entry skid FIFO.
`timescale 1ns/1ps
module anticipator_req_stage #(
  parameter int SLOTS = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [SLOTS-1:0]   in_en,
  input  logic [4*SLOTS-1:0] in_hi,
  input  logic [8*SLOTS-1:0] in_jc,
  input  logic [4*SLOTS-1:0] in_lo,
  output logic [11:0]        read0_addr,
  output logic [11:0]        read1_addr,
  output logic [11:0]        read2_addr,
  output logic [11:0]        read3_addr,
  input  logic [1:0]         read0_data,
  input  logic [1:0]         read1_data,
  input  logic [1:0]         read2_data,
  input  logic [1:0]         read3_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [2*SLOTS-1:0] out_hint,
  output logic [SLOTS-1:0]   out_take,
  output logic               out_any,
  output logic [1:0]         out_first,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int PC_W = $clog2(SLOTS + 1);

  typedef struct packed {
    logic [2*SLOTS-1:0] hint;
    logic [SLOTS-1:0]   take;
    logic               any;
    logic [1:0]         first;
  } entry_t;

  logic [11:0]      addr  [SLOTS];
  logic [1:0]       rdata [SLOTS];
  entry_t           new_entry;
  logic [SLOTS-1:0] unused_jc_lo;

  assign rdata[0]   = read0_data;
  assign rdata[1]   = read1_data;
  assign rdata[2]   = read2_data;
  assign rdata[3]   = read3_data;
  assign read0_addr = addr[0];
  assign read1_addr = addr[1];
  assign read2_addr = addr[2];
  assign read3_addr = addr[3];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    addr         = '{default: 12'h000};
    new_entry    = '0;
    unused_jc_lo = '0;
    // Descending scan so the lowest taken slot is the last one to set first.
    for (int s = SLOTS - 1; s >= 0; s--) begin
      unused_jc_lo[s] = ^in_jc[8*s +: 4];
      if (in_vld && in_en[s]) begin
        addr[s] = {in_hi[4*s +: 4], in_jc[8*s+4 +: 4], in_lo[4*s +: 4]};
      end
      new_entry.hint[2*s +: 2] = in_en[s] ? rdata[s] : 2'b00;
      new_entry.take[s]        = (new_entry.hint[2*s +: 2] == 2'b11);
      if (new_entry.take[s]) begin
        new_entry.first = 2'(s);
      end
    end
    new_entry.any = |new_entry.take;
  end

  entry_t     fifo_q [2];
  entry_t     head;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_rdy  = (count_q != 2'd2) && !flush;
  assign push    = in_vld && in_rdy;
  assign out_vld = (count_q != 2'd0);
  assign pop     = out_vld && out_rdy;

  assign head      = fifo_q[rd_ptr_q];
  assign out_hint  = head.hint;
  assign out_take  = head.take;
  assign out_any   = head.any;
  assign out_first = head.first;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  logic [CNT_W-1:0] hit_q, hit_d;
  logic [PC_W-1:0]  pop_n;
  logic [CNT_W:0]   hit_sum;

  always_comb begin
    pop_n = '0;
    for (int s = 0; s < SLOTS; s++) begin
      pop_n = pop_n + PC_W'(head.take[s]);
    end
    hit_sum = {1'b0, hit_q} + (CNT_W+1)'(pop_n);
    hit_d   = hit_q;
    if (stat_clr) begin
      hit_d = '0;
    end else if (pop) begin
      hit_d = hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
    end
  end

  assign hit_cnt = hit_q;

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      hit_q     <= '0;
      // NOTE: the storage array is reset too, because the head entry drives
      // out_* directly and must read as zero while the FIFO is empty.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hit_q    <= hit_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_anticipator_req_stage.sv
// Scoreboard bench for anticipator_req_stage: a behavioural RAM/index model
// predicts each accepted bundle; a monitor pops and compares at the output.
`timescale 1ns/1ps
module tb_anticipator_req_stage;

  typedef struct packed {
    logic [7:0] hint;
    logic [3:0] take;
    logic       any;
    logic [1:0] first;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [3:0]  in_en = '0;
  logic [15:0] in_hi = '0;
  logic [31:0] in_jc = '0;
  logic [15:0] in_lo = '0;
  logic [11:0] read0_addr, read1_addr, read2_addr, read3_addr;
  logic [1:0]  read0_data, read1_data, read2_data, read3_data;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [7:0]  out_hint;
  logic [3:0]  out_take;
  logic        out_any;
  logic [1:0]  out_first;
  logic        stat_clr = 1'b0;
  logic [15:0] hit_cnt;

  logic [1:0]  ram [4096];
  entry_t      q [$];
  int          exp_hit = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        last_pushed = 1'b0;
  int          last_steps = 0;

  always #5 clk = ~clk;

  assign read0_data = ram[read0_addr];
  assign read1_data = ram[read1_addr];
  assign read2_data = ram[read2_addr];
  assign read3_data = ram[read3_addr];

  anticipator_req_stage #(.SLOTS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_en(in_en), .in_hi(in_hi), .in_jc(in_jc), .in_lo(in_lo),
    .read0_addr(read0_addr), .read1_addr(read1_addr),
    .read2_addr(read2_addr), .read3_addr(read3_addr),
    .read0_data(read0_data), .read1_data(read1_data),
    .read2_data(read2_data), .read3_data(read3_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_hint(out_hint),
    .out_take(out_take), .out_any(out_any), .out_first(out_first),
    .stat_clr(stat_clr), .hit_cnt(hit_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lookup index of slot s as plain arithmetic: hi*256 + jc_upper_nibble*16 + lo.
  function automatic int slot_index(int s);
    return int'(in_hi[4*s +: 4]) * 256 + (int'(in_jc[8*s +: 8]) / 16) * 16 + int'(in_lo[4*s +: 4]);
  endfunction

  function automatic logic [47:0] exp_addrs();
    logic [47:0] a = '0;
    for (int s = 0; s < 4; s++)
      if (in_vld && in_en[s]) a[12*s +: 12] = 12'(slot_index(s));
    return a;
  endfunction

  function automatic entry_t model();
    entry_t e = '0;
    bit found = 0;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] h;
      h = in_en[s] ? ram[slot_index(s)] : 2'b00;
      e.hint[2*s +: 2] = h;
      if (h == 2'b11) begin
        e.take[s] = 1'b1;
        if (!found) begin
          e.first = 2'(s);
          found = 1;
        end
      end
    end
    e.any = (e.take != 0);
    return e;
  endfunction

  // One clock: check combinational outputs at the falling edge, update the
  // reference queue at the rising edge, return 1 ns after it.
  task automatic step();
    int     sz;
    logic   rs, fl, pushed;
    entry_t e;
    sz = q.size();
    @(negedge clk);
    rs = rst;
    fl = flush;
    check("read_addr", {16'h0, read3_addr, read2_addr, read1_addr, read0_addr}, {16'h0, exp_addrs()});
    if (rs) check("in_rdy", in_rdy, (sz != 2) && !fl);
    pushed = rs && in_vld && in_rdy;
    e = model();
    @(posedge clk);
    if (!rs || fl) q.delete();
    else if (pushed) q.push_back(e);
    last_pushed = pushed;
    #1;
  endtask

  task automatic send(input logic [3:0] en, input logic [15:0] hi,
                      input logic [31:0] jc, input logic [15:0] lo);
    in_en = en; in_hi = hi; in_jc = jc; in_lo = lo; in_vld = 1'b1;
    last_steps = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      last_steps++;
      if (last_pushed) break;
    end
    check("send_accepted", last_pushed, 1'b1);
    in_vld = 1'b0;
  endtask

  task automatic send_rand();
    send(4'($urandom), 16'($urandom), $urandom, 16'($urandom));
  endtask

  task automatic drain();
    in_vld = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 0);
    check("drain_out_vld", out_vld, 1'b0);
  endtask

  // Monitor: compare the head entry and the hit counter every cycle.
  initial begin
    entry_t e;
    int     pop_n;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_hit = 0;
      end else begin
        pop_n = 0;
        check("hit_cnt", hit_cnt, 64'(exp_hit));
        check("out_vld", out_vld, q.size() != 0);
        if (out_vld && q.size() != 0) begin
          e = q[0];
          check("out_hint", out_hint, e.hint);
          check("out_take", out_take, e.take);
          check("out_any", out_any, e.any);
          check("out_first", out_first, e.first);
          if (out_rdy) begin
            pop_n = $countones(e.take);
            void'(q.pop_front());
          end
        end
        if (stat_clr) exp_hit = 0;
        else exp_hit = (exp_hit + pop_n > 65535) ? 65535 : exp_hit + pop_n;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 2'($urandom_range(0, 3));

    // Reset
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_hint", out_hint, 8'h00);
    check("rst_out_take", out_take, 4'h0);
    check("rst_out_any", out_any, 1'b0);
    check("rst_out_first", out_first, 2'd0);
    check("rst_hit_cnt", hit_cnt, 16'h0);
    check("rst_in_rdy", in_rdy, 1'b1);

    // Directed single bundle with a known RAM image
    ram[12'h081] = 2'b11;
    ram[12'h282] = 2'b00;
    ram[12'h444] = 2'b11;
    out_rdy = 1'b1;
    in_vld = 1'b1; in_en = 4'b0111; in_hi = 16'h0420; in_jc = 32'h0040_8080; in_lo = 16'h0421;
    #1;
    check("t1_read0_addr", read0_addr, 12'h081);
    check("t1_read3_addr", read3_addr, 12'h000);
    send(4'b0111, 16'h0420, 32'h0040_8080, 16'h0421);
    check("t1_out_vld", out_vld, 1'b1);
    check("t1_out_hint", out_hint, 8'b00_11_00_11);
    check("t1_out_take", out_take, 4'b0101);
    check("t1_out_any", out_any, 1'b1);
    check("t1_out_first", out_first, 2'd0);

    // Same bundle with slot 0 disabled
    send(4'b0110, 16'h0420, 32'h0040_8080, 16'h0421);
    check("t2_out_take", out_take, 4'b0100);
    check("t2_out_first", out_first, 2'd2);
    drain();

    // Back-pressure: third bundle held until the consumer drains
    out_rdy = 1'b0;
    send_rand();
    send_rand();
    check("bp_full_in_rdy", in_rdy, 1'b0);
    in_vld = 1'b1;
    step();
    check("bp_third_held", last_pushed, 1'b0);
    out_rdy = 1'b1;
    send_rand();
    drain();

    // Steady stream at count=1: one bundle accepted per cycle
    out_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_rand();
      check("stream_no_bubble", last_steps, 1);
      check("stream_in_rdy", in_rdy, 1'b1);
    end
    drain();

    // Flush with two entries held and a bundle offered
    out_rdy = 1'b0;
    send_rand();
    send_rand();
    in_vld = 1'b1; in_en = 4'hF;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_vld = 1'b0;
    check("flush_dropped", last_pushed, 1'b0);
    check("flush_out_vld", out_vld, 1'b0);
    check("flush_hit_cnt", hit_cnt, 64'(exp_hit));
    out_rdy = 1'b1;
    repeat (3) step();

    // Randomised traffic including flushes, counter clears and one reset
    for (int i = 0; i < 3000; i++) begin
      in_en = 4'($urandom); in_hi = 16'($urandom); in_jc = $urandom; in_lo = 16'($urandom);
      in_vld   = ($urandom_range(0, 9) < 7);
      out_rdy  = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 49) == 0);
      stat_clr = ($urandom_range(0, 49) == 0);
      rst      = (i != 1500);
      step();
    end
    flush = 1'b0; stat_clr = 1'b0; rst = 1'b1;
    drain();

    // Saturation: bring hit_cnt to 0xFFFE, then overflow it
    ram[12'hFFF] = 2'b11;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("sat_cleared", hit_cnt, 16'h0000);
    send(4'b0011, 16'hFFFF, 32'hF5FA_F3FC, 16'hFFFF);
    for (int i = 0; i < 16383; i++) send(4'b1111, 16'hFFFF, 32'hF0F1_F2F3, 16'hFFFF);
    drain();
    check("sat_preload", hit_cnt, 16'hFFFE);
    send(4'b1111, 16'hFFFF, 32'hF0F0_F0F0, 16'hFFFF);
    drain();
    check("sat_ffff", hit_cnt, 16'hFFFF);
    send(4'b1111, 16'hFFFF, 32'hF0F0_F0F0, 16'hFFFF);
    drain();
    check("sat_no_wrap", hit_cnt, 16'hFFFF);

    // stat_clr beats a simultaneous pop
    out_rdy = 1'b0;
    send(4'b1111, 16'hFFFF, 32'hF0F0_F0F0, 16'hFFFF);
    check("clr_pending", out_vld, 1'b1);
    stat_clr = 1'b1;
    out_rdy = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_with_pop", hit_cnt, 16'h0000);
    check("clr_popped", out_vld, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
